// File: rtl/mips_debug_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_debug_ctrl_pkg
// Shared definitions for the MIPS debug controller:
//   - FSM state encodings (also exported on o_state for debug)
//   - host command byte values
//   - halt instruction and pipeline drain length
//   - is_halt() helper used for both preload and IF/ID halt detection
// ---------------------------------------------------------------------------
package mips_debug_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_LOAD = 3'd0,
      ST_CMD  = 3'd1,
      ST_RUN  = 3'd2,
      ST_STEP = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   localparam logic [7:0]  CMD_RUN    = 8'h43;
   localparam logic [7:0]  CMD_STEP   = 8'h53;
   localparam logic [7:0]  CMD_RELOAD = 8'h52;

   localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;

   // Enabled cycles spent draining the pipeline once the halt reaches IF/ID.
   localparam int NB_DRAIN   = 4;
   localparam int NB_DRAIN_W = $clog2(NB_DRAIN + 1);
   localparam logic [NB_DRAIN_W-1:0] DRAIN_DONE = NB_DRAIN_W'(NB_DRAIN);
   localparam logic [NB_DRAIN_W-1:0] DRAIN_ZERO = {NB_DRAIN_W{1'b0}};

   function automatic logic is_halt(input logic [31:0] word);
      return (word == HALT_WORD);
   endfunction

endpackage

// File: rtl/mips_word_assembler.sv
// ---------------------------------------------------------------------------
// mips_word_assembler
// Collects four host bytes, most significant byte first, into one 32-bit
// instruction word.
//   i_clk, i_rst   : clock, asynchronous active-low reset
//   i_clear        : synchronous clear, drops any partial word
//   i_byte_valid   : a byte is accepted this cycle
//   i_byte         : accepted byte
//   o_word_valid   : high in the cycle the 4th byte is accepted
//   o_word         : assembled word, valid together with o_word_valid
// The word is presented combinationally in the accepting cycle; the parent
// registers it, so the write strobe appears on the following cycle.
// ---------------------------------------------------------------------------
module mips_word_assembler #(
   parameter int LEN = 32
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_clear,
   input  logic           i_byte_valid,
   input  logic [7:0]     i_byte,
   output logic           o_word_valid,
   output logic [LEN-1:0] o_word
);

   logic [1:0]     cnt_q;
   logic [1:0]     cnt_d;
   logic [LEN-9:0] shift_q;
   logic [LEN-9:0] shift_d;

   // Next-state for the byte counter and the three-byte shift register.
   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      if (i_clear) begin
         cnt_d   = 2'd0;
         shift_d = {(LEN-8){1'b0}};
      end else if (i_byte_valid) begin
         // Counter wraps naturally from 3 to 0 on the 4th byte.
         cnt_d   = cnt_q + 2'd1;
         shift_d = {shift_q[LEN-17:0], i_byte};
      end else begin
         cnt_d   = cnt_q;
         shift_d = shift_q;
      end
   end

   // Byte counter and shift register state.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt_q   <= 2'd0;
         shift_q <= {(LEN-8){1'b0}};
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

   assign o_word_valid = i_byte_valid && !i_clear && (cnt_q == 2'd3);
   assign o_word       = {shift_q, i_byte};

endmodule

// File: rtl/mips_debug_ctrl.sv
// ---------------------------------------------------------------------------
// mips_debug_ctrl
// Host-driven sequencer for the MIPS pipeline top: preloads program memory
// from a byte stream with the CPU held in reset, then runs or single-steps
// the CPU, counts executed cycles, detects the halt word in IF/ID and drains
// the pipeline before reporting done.
// Ports:
//   i_clk, i_rst            : clock, asynchronous active-low reset
//   i_rx_data/valid, o_rx_ready : host byte handshake
//   i_if_id_instr           : instruction currently in the IF/ID latch
//   o_cpu_rst_n             : CPU reset (low = held)
//   o_preload_flag/address/instruction : program-memory write port
//   o_cpu_enable            : CPU clock enable
//   o_cycle_count           : executed cycles (saturating)
//   o_done                  : program finished and drained
//   o_load_error            : memory filled without a halt word (sticky)
//   o_state                 : FSM state for debug
// All outputs are registered.
// ---------------------------------------------------------------------------
module mips_debug_ctrl
   import mips_debug_ctrl_pkg::*;
#(
   parameter int LEN               = 32,
   parameter int NB_ADDRESS        = 16,
   parameter int RAM_DEPTH_PROGRAM = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_valid,
   output logic                  o_rx_ready,
   input  logic [LEN-1:0]        i_if_id_instr,
   output logic                  o_cpu_rst_n,
   output logic                  o_preload_flag,
   output logic [NB_ADDRESS-1:0] o_preload_address,
   output logic [LEN-1:0]        o_preload_instruction,
   output logic                  o_cpu_enable,
   output logic [LEN-1:0]        o_cycle_count,
   output logic                  o_done,
   output logic                  o_load_error,
   output logic [2:0]            o_state
);

   localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(RAM_DEPTH_PROGRAM - 1);
   localparam logic [LEN-1:0]        CYC_MAX   = {LEN{1'b1}};

   state_e                  state_q,     state_d;
   logic [NB_ADDRESS-1:0]   addr_q,      addr_d;
   logic                    flag_q,      flag_d;
   logic [LEN-1:0]          instr_q,     instr_d;
   logic                    en_q,        en_d;
   logic [LEN-1:0]          cyc_q,       cyc_d;
   logic [NB_DRAIN_W-1:0]   drain_q,     drain_d;
   logic                    err_q,       err_d;
   logic                    done_q,      done_d;
   logic                    ready_q,     ready_d;
   logic                    cpu_rst_n_q, cpu_rst_n_d;

   logic                    rx_accept_s;
   logic                    asm_valid_s;
   logic [LEN-1:0]          asm_word_s;
   logic                    reload_s;
   logic                    drain_hit_s;

   assign rx_accept_s = i_rx_valid && ready_q;

   mips_word_assembler #(
      .LEN (LEN)
   ) u_word_assembler (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clear      (reload_s),
      .i_byte_valid (rx_accept_s && (state_q == ST_LOAD)),
      .i_byte       (i_rx_data),
      .o_word_valid (asm_valid_s),
      .o_word       (asm_word_s)
   );

   // Next-state logic: FSM, preload address, execution counters and outputs.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      flag_d      = 1'b0;
      instr_d     = instr_q;
      en_d        = 1'b0;
      cyc_d       = cyc_q;
      drain_d     = drain_q;
      err_d       = err_q;
      reload_s    = 1'b0;
      drain_hit_s = 1'b0;

      // Execution accounting happens on every cycle the CPU was enabled.
      // Once the halt is seen the drain counter keeps running on its own.
      if (en_q && (drain_q != DRAIN_DONE)) begin
         if (cyc_q != CYC_MAX) begin
            cyc_d = cyc_q + LEN'(1);
         end else begin
            cyc_d = cyc_q;
         end
         if (is_halt(i_if_id_instr) || (drain_q != DRAIN_ZERO)) begin
            drain_d = drain_q + NB_DRAIN_W'(1);
         end else begin
            drain_d = drain_q;
         end
         drain_hit_s = (drain_d == DRAIN_DONE);
      end else begin
         cyc_d       = cyc_q;
         drain_d     = drain_q;
         drain_hit_s = 1'b0;
      end

      case (state_q)
         ST_LOAD: begin
            if (flag_q) begin
               // Write cycle: the strobe is on the outputs now, advance.
               addr_d = addr_q + NB_ADDRESS'(1);
               if (is_halt(instr_q)) begin
                  state_d = ST_CMD;
               end else if (addr_q == LAST_ADDR) begin
                  err_d   = 1'b1;
                  state_d = ST_CMD;
               end else begin
                  state_d = ST_LOAD;
               end
            end else if (asm_valid_s) begin
               flag_d  = 1'b1;
               instr_d = asm_word_s;
            end else begin
               flag_d  = 1'b0;
            end
         end
         ST_CMD: begin
            if (rx_accept_s) begin
               case (i_rx_data)
                  CMD_RUN: begin
                     state_d = ST_RUN;
                     en_d    = 1'b1;
                  end
                  CMD_STEP: begin
                     state_d = ST_STEP;
                     en_d    = 1'b1;
                  end
                  CMD_RELOAD: reload_s = 1'b1;
                  default:    state_d  = ST_CMD;
               endcase
            end else begin
               state_d = ST_CMD;
            end
         end
         ST_RUN: begin
            if (drain_hit_s) begin
               state_d = ST_DONE;
               en_d    = 1'b0;
            end else begin
               en_d    = 1'b1;
            end
         end
         ST_STEP: begin
            if (rx_accept_s && (i_rx_data == CMD_RELOAD)) begin
               reload_s = 1'b1;
            end else if (drain_hit_s) begin
               state_d = ST_DONE;
            end else if (rx_accept_s) begin
               case (i_rx_data)
                  CMD_STEP: en_d = 1'b1;
                  CMD_RUN: begin
                     state_d = ST_RUN;
                     en_d    = 1'b1;
                  end
                  default: state_d = ST_STEP;
               endcase
            end else begin
               state_d = ST_STEP;
            end
         end
         ST_DONE: begin
            if (rx_accept_s && (i_rx_data == CMD_RELOAD)) begin
               reload_s = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_LOAD;
      endcase

      // Reload returns to a fresh load; program memory itself is not cleared.
      if (reload_s) begin
         state_d = ST_LOAD;
         addr_d  = {NB_ADDRESS{1'b0}};
         flag_d  = 1'b0;
         en_d    = 1'b0;
         cyc_d   = {LEN{1'b0}};
         drain_d = DRAIN_ZERO;
         err_d   = 1'b0;
      end else begin
         state_d = state_d;
      end

      // Ready drops for the write cycle so a byte never lands on a strobe.
      case (state_d)
         ST_LOAD: ready_d = !flag_d;
         ST_RUN:  ready_d = 1'b0;
         default: ready_d = 1'b1;
      endcase

      cpu_rst_n_d = (state_d != ST_LOAD);
      done_d      = (state_d == ST_DONE);
   end

   // Single register bank for FSM state and all registered outputs.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= ST_LOAD;
         addr_q      <= {NB_ADDRESS{1'b0}};
         flag_q      <= 1'b0;
         instr_q     <= {LEN{1'b0}};
         en_q        <= 1'b0;
         cyc_q       <= {LEN{1'b0}};
         drain_q     <= DRAIN_ZERO;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= 1'b0;
         cpu_rst_n_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         flag_q      <= flag_d;
         instr_q     <= instr_d;
         en_q        <= en_d;
         cyc_q       <= cyc_d;
         drain_q     <= drain_d;
         err_q       <= err_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
         cpu_rst_n_q <= cpu_rst_n_d;
      end
   end

   assign o_rx_ready            = ready_q;
   assign o_cpu_rst_n           = cpu_rst_n_q;
   assign o_preload_flag        = flag_q;
   assign o_preload_address     = addr_q;
   assign o_preload_instruction = instr_q;
   assign o_cpu_enable          = en_q;
   assign o_cycle_count         = cyc_q;
   assign o_done                = done_q;
   assign o_load_error          = err_q;
   assign o_state               = state_q;

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_debug_ctrl
// Directed bench: load, run, step, overflow, reload and async reset.
// ---------------------------------------------------------------------------
module tb_mips_debug_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [7:0]  i_rx_data;
   logic        i_rx_valid;
   logic        o_rx_ready;
   logic [31:0] i_if_id_instr;
   logic        o_cpu_rst_n;
   logic        o_preload_flag;
   logic [15:0] o_preload_address;
   logic [31:0] o_preload_instruction;
   logic        o_cpu_enable;
   logic [31:0] o_cycle_count;
   logic        o_done;
   logic        o_load_error;
   logic [2:0]  o_state;

   int checks   = 0;
   int failures = 0;

   // Monitor records
   logic [15:0] st_addr[$];
   logic [31:0] st_data[$];
   int          rdy_viol = 0;
   int          en_total = 0;
   int          en_rise  = 0;
   logic        en_prev  = 1'b0;

   always #5 i_clk = ~i_clk;

   mips_debug_ctrl dut (
      .i_clk                 (i_clk),
      .i_rst                 (i_rst),
      .i_rx_data             (i_rx_data),
      .i_rx_valid            (i_rx_valid),
      .o_rx_ready            (o_rx_ready),
      .i_if_id_instr         (i_if_id_instr),
      .o_cpu_rst_n           (o_cpu_rst_n),
      .o_preload_flag        (o_preload_flag),
      .o_preload_address     (o_preload_address),
      .o_preload_instruction (o_preload_instruction),
      .o_cpu_enable          (o_cpu_enable),
      .o_cycle_count         (o_cycle_count),
      .o_done                (o_done),
      .o_load_error          (o_load_error),
      .o_state               (o_state)
   );

   // Sample outputs on the falling edge: write strobes and enable pulses.
   always @(negedge i_clk) begin
      if (o_preload_flag === 1'b1) begin
         st_addr.push_back(o_preload_address);
         st_data.push_back(o_preload_instruction);
         if (o_rx_ready !== 1'b0) rdy_viol <= rdy_viol + 1;
      end
      if (o_cpu_enable === 1'b1) en_total <= en_total + 1;
      if (o_cpu_enable === 1'b1 && en_prev === 1'b0) en_rise <= en_rise + 1;
      en_prev <= o_cpu_enable;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      while (o_rx_ready !== 1'b1 && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      chk("rx_accept_timeout", 32'(n < 50), 32'd1);
      @(negedge i_clk);
      i_rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int en0;
      int r0;
      i_rst         = 1'b0;
      i_rx_data     = 8'h00;
      i_rx_valid    = 1'b0;
      i_if_id_instr = 32'h0000_0000;
      repeat (3) @(negedge i_clk);

      // ---- reset state ----
      chk("rst_state",     32'(o_state),               32'd0);
      chk("rst_cpu_rst_n", 32'(o_cpu_rst_n),           32'd0);
      chk("rst_rx_ready",  32'(o_rx_ready),            32'd0);
      chk("rst_flag",      32'(o_preload_flag),        32'd0);
      chk("rst_addr",      32'(o_preload_address),     32'd0);
      chk("rst_instr",     o_preload_instruction,      32'd0);
      chk("rst_enable",    32'(o_cpu_enable),          32'd0);
      chk("rst_cycles",    o_cycle_count,              32'd0);
      chk("rst_done",      32'(o_done),                32'd0);
      chk("rst_err",       32'(o_load_error),          32'd0);
      i_rst = 1'b1;
      @(negedge i_clk);
      chk("load_rx_ready", 32'(o_rx_ready),            32'd1);

      // ---- load: 20010005, FFFFFFFF ----
      base = st_addr.size();
      send_word(32'h2001_0005);
      send_word(32'hFFFF_FFFF);
      repeat (3) @(negedge i_clk);
      #1;
      chk("load_strobes",  32'(st_addr.size() - base), 32'd2);
      chk("load_addr0",    32'(st_addr[base]),         32'd0);
      chk("load_data0",    st_data[base],              32'h2001_0005);
      chk("load_addr1",    32'(st_addr[base+1]),       32'd1);
      chk("load_data1",    st_data[base+1],            32'hFFFF_FFFF);
      chk("load_state",    32'(o_state),               32'd1);
      chk("load_cpu_rst",  32'(o_cpu_rst_n),           32'd1);
      chk("load_err",      32'(o_load_error),          32'd0);
      chk("load_rdy_wr",   32'(rdy_viol),              32'd0);

      // ---- run: halt on 2nd enabled cycle ----
      en0 = en_total;
      send_byte(8'h43);
      chk("run_en_e1",     32'(o_cpu_enable),          32'd1);
      @(negedge i_clk);
      i_if_id_instr = 32'hFFFF_FFFF;
      chk("run_rx_ready",  32'(o_rx_ready),            32'd0);
      @(negedge i_clk);
      i_if_id_instr = 32'h0000_0000;
      repeat (5) @(negedge i_clk);
      #1;
      chk("run_en_cycles", 32'(en_total - en0),        32'd5);
      chk("run_cycles",    o_cycle_count,              32'd5);
      chk("run_done",      32'(o_done),                32'd1);
      chk("run_state",     32'(o_state),               32'd4);
      chk("run_en_off",    32'(o_cpu_enable),          32'd0);

      // ---- DONE ignores a step byte ----
      send_byte(8'h53);
      repeat (2) @(negedge i_clk);
      #1;
      chk("done_ign_state",  32'(o_state),             32'd4);
      chk("done_ign_cycles", o_cycle_count,            32'd5);
      chk("done_ign_en",     32'(en_total - en0),      32'd5);

      // ---- reload from DONE ----
      send_byte(8'h52);
      chk("rl_state",      32'(o_state),               32'd0);
      chk("rl_cpu_rst",    32'(o_cpu_rst_n),           32'd0);
      chk("rl_cycles",     o_cycle_count,              32'd0);
      chk("rl_done",       32'(o_done),                32'd0);

      base = st_addr.size();
      send_word(32'h0000_0000);
      send_word(32'hFFFF_FFFF);
      repeat (3) @(negedge i_clk);
      #1;
      chk("rl_addr0",      32'(st_addr[base]),         32'd0);
      chk("rl_data0",      st_data[base],              32'h0000_0000);
      chk("rl_addr1",      32'(st_addr[base+1]),       32'd1);
      chk("rl_state_cmd",  32'(o_state),               32'd1);

      // ---- step: three pulses with gaps ----
      en0 = en_total;
      r0  = en_rise;
      send_byte(8'h53);
      repeat (3) @(negedge i_clk);
      send_byte(8'h53);
      repeat (3) @(negedge i_clk);
      send_byte(8'h53);
      repeat (4) @(negedge i_clk);
      #1;
      chk("step_en_cycles", 32'(en_total - en0),       32'd3);
      chk("step_pulses",    32'(en_rise - r0),         32'd3);
      chk("step_cycles",    o_cycle_count,             32'd3);
      chk("step_state",     32'(o_state),              32'd3);
      chk("step_done",      32'(o_done),               32'd0);

      // ---- reload from STEP, then overflow with 32 non-halt words ----
      send_byte(8'h52);
      chk("rl2_state",     32'(o_state),               32'd0);
      base = st_addr.size();
      for (int i = 0; i < 32; i++) send_word(32'h0000_0000);
      repeat (4) @(negedge i_clk);
      #1;
      chk("ovf_strobes",   32'(st_addr.size() - base), 32'd32);
      for (int i = 0; i < 32; i++) begin
         if (base + i < st_addr.size()) chk("ovf_addr", 32'(st_addr[base+i]), 32'(i));
         else chk("ovf_addr_missing", 32'(base + i), 32'(st_addr.size()));
      end
      chk("ovf_err",       32'(o_load_error),          32'd1);
      chk("ovf_state",     32'(o_state),               32'd1);
      chk("ovf_cpu_rst",   32'(o_cpu_rst_n),           32'd1);

      // ---- reload from CMD clears error ----
      send_byte(8'h52);
      chk("rl3_state",     32'(o_state),               32'd0);
      chk("rl3_err",       32'(o_load_error),          32'd0);

      // ---- async reset mid-word ----
      send_byte(8'hAA);
      send_byte(8'hBB);
      #2;
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("ar_state",      32'(o_state),               32'd0);
      chk("ar_rx_ready",   32'(o_rx_ready),            32'd0);
      chk("ar_cpu_rst",    32'(o_cpu_rst_n),           32'd0);
      i_rst = 1'b1;
      base = st_addr.size();
      send_word(32'h1122_3344);
      repeat (3) @(negedge i_clk);
      #1;
      chk("ar_strobes",    32'(st_addr.size() - base), 32'd1);
      chk("ar_addr",       32'(st_addr[base]),         32'd0);
      chk("ar_data",       st_data[base],              32'h1122_3344);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_debug_ctrl.md
Name: mips_debug_ctrl

Overview:
- Sequences the MIPS pipeline top from a byte-stream host link, usually a UART receiver.
- Phases:
  - Load: assemble 32-bit instructions and preload them into program memory while the CPU is held in reset.
  - Command: accept a run or step command.
  - Execute: gate the CPU clock enable, count execution cycles, detect the halt word in IF/ID and drain the pipeline.
  - Done: report completion.
- Sits between the host receiver and the top-level CPU preload/step inputs.

Parameters:
- LEN, 32, instruction/data word width.
- NB_ADDRESS, 16, preload address width.
- RAM_DEPTH_PROGRAM, 32, number of program words; last writable address is RAM_DEPTH_PROGRAM-1.
- HALT_WORD, 32'hFFFFFFFF, end-of-program / halt instruction.
- NB_DRAIN, 4, enabled cycles after halt detection before done.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous active-low reset.
- i_rx_data  in  8  host byte.
- i_rx_valid  in  1  host byte valid.
- o_rx_ready  out  1  byte accepted this cycle when high together with i_rx_valid.
- i_if_id_instr  in  LEN  instruction field of the IF/ID latch.
- o_cpu_rst_n  out  1  CPU reset, low = held in reset.
- o_preload_flag  out  1  one-cycle program-memory write strobe.
- o_preload_address  out  NB_ADDRESS  write address.
- o_preload_instruction  out  LEN  write data.
- o_cpu_enable  out  1  CPU advances one pipeline cycle when high.
- o_cycle_count  out  LEN  executed cycles.
- o_done  out  1  program finished and pipeline drained.
- o_load_error  out  1  sticky: memory filled without HALT_WORD.
- o_state  out  3  current FSM state, for debug.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - State = LOAD.
  - All outputs 0, including o_cpu_rst_n=0.
  - Byte counter, address, cycle counter and drain counter = 0.
- States: LOAD=0, CMD=1, RUN=2, STEP=3, DONE=4.
- LOAD:
  - o_rx_ready=1, o_cpu_rst_n=0.
  - Bytes are shifted in MSB first; a 2-bit byte counter wraps on the 4th byte.
  - The cycle after the 4th byte is accepted: o_preload_flag=1 for exactly one cycle, with the assembled word and current address; the address then increments.
  - o_rx_ready=0 during the write cycle.
  - If the word == HALT_WORD, it is still written, then next state = CMD.
  - If the write is at address RAM_DEPTH_PROGRAM-1 and the word != HALT_WORD: o_load_error=1, next state = CMD. The address never wraps.
- CMD:
  - o_cpu_rst_n=1, o_rx_ready=1.
  - 0x43 'C' -> RUN; 0x53 'S' -> STEP plus one enable pulse; 0x52 'R' -> reload; any other byte is ignored.
- Reload (0x52 accepted in CMD, STEP or DONE):
  - Next state = LOAD; address, counters, o_done and o_load_error cleared; o_cpu_rst_n=0 the next cycle.
- RUN:
  - o_cpu_enable=1 every cycle; o_rx_ready=0.
- STEP:
  - o_rx_ready=1.
  - Each accepted 0x53 gives o_cpu_enable=1 for exactly one cycle, the cycle after acceptance.
  - 0x43 switches to RUN; 0x52 reloads; other bytes are ignored.
- Execute accounting, on every cycle with o_cpu_enable=1:
  - o_cycle_count increments while drain counter != NB_DRAIN.
  - Once i_if_id_instr == HALT_WORD is sampled with enable high, the drain counter increments on every enabled cycle, including that one.
  - When the drain counter reaches NB_DRAIN: next state = DONE, o_cpu_enable=0 from the next cycle, o_done=1.
- DONE:
  - Counter frozen; o_rx_ready=1; only 0x52 is acted on.
- Simultaneous events:
  - A halt seen on the same cycle as a step pulse counts for both the cycle and the drain.
  - A byte arriving in RUN is not accepted; it stays pending at the source.
- o_cycle_count saturates at all-ones.
- Reset mid-load discards the partial word. Memory contents are not cleared; the next load overwrites them.

Decomposition:
- Shared package contents: state encodings; command byte constants (CMD_RUN=8'h43, CMD_STEP=8'h53, CMD_RELOAD=8'h52); HALT_WORD; NB_DRAIN.
- One natural sub-module, mips_word_assembler: byte counter plus shift register, producing a word-valid pulse and the assembled word.
- The FSM, address counter and execution counters stay in mips_debug_ctrl.

Test Plan:
- Load: send 8 bytes 20 01 00 05 FF FF FF FF.
  - -> Strobe at addr 0 with 32'h20010005.
  - -> Strobe at addr 1 with 32'hFFFFFFFF.
  - -> State CMD; o_cpu_rst_n rises; o_load_error=0.
- Run: after the previous load, send 0x43 and drive i_if_id_instr=32'hFFFFFFFF on the 2nd enabled cycle.
  - -> o_cpu_enable stays high 5 cycles total.
  - -> o_cycle_count=5, o_done=1, state DONE.
- Step: send 0x53 three times with gaps.
  - -> Exactly three one-cycle enable pulses; o_cycle_count=3; state remains STEP.
- Overflow: send 32 non-halt words (32'h00000000).
  - -> 32 strobes at addresses 0..31.
  - -> o_load_error=1; state CMD; no write to address 32.
- Reload: from DONE send 0x52.
  - -> State LOAD; o_cpu_rst_n=0; counters and o_done cleared.
  - -> Next word is written at address 0.
- Async reset: assert i_rst=0 after 2 bytes of a word, release, then send 4 bytes of 32'h11223344.
  - -> Strobe at addr 0 with 32'h11223344.
